// File: rtl/g1_pkg.sv
// Shared definitions for the g1 arbiter: default widths, requester count and
// the FSM state encoding.
package g1_pkg;

    localparam int G1_NREQ = 4;
    localparam int G1_XW   = 4;
    localparam int G1_YW   = 2;
    localparam int G1_IDW  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } g1_state_e;

endpackage

// File: rtl/g1_arbiter_if.sv
// Requester/consumer bus of the g1 arbiter: level requests with operands in,
// one-hot grant pulse and a valid/ready result channel out.
interface g1_arbiter_if #(
    parameter int NREQ = g1_pkg::G1_NREQ,
    parameter int XW   = g1_pkg::G1_XW,
    parameter int YW   = g1_pkg::G1_YW
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [YW-1:0]      rsp_y;
    logic               rsp_ready;

    modport slave (
        input  req, req_x, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_y
    );

    modport master (
        output req, req_x, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_y
    );

endinterface

// File: rtl/g1_arbiter_g1.sv
// Shared g1 function unit: folds the operand bits into the result width by XOR,
// so bit i of x contributes to bit (i mod YW) of y.
module g1_behavioral
    import g1_pkg::*;
#(
    parameter int XW = G1_XW,
    parameter int YW = G1_YW
) (
    input  logic [XW-1:0] x,
    output logic [YW-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < XW; i++) begin
            y[i % YW] = y[i % YW] ^ x[i];
        end
    end

endmodule

// File: rtl/g1_arbiter.sv
// Round-robin arbiter sharing one g1 unit between NREQ requesters; one operand
// in flight at a time, result held on a valid/ready channel until consumed.
module g1_arbiter
    import g1_pkg::*;
#(
    parameter int NREQ = G1_NREQ,
    parameter int XW   = G1_XW,
    parameter int YW   = G1_YW
) (
    input  logic         clk,
    input  logic         rst_n,
    g1_arbiter_if.slave  bus
);

    g1_state_e          state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [G1_IDW-1:0]  id_q, id_d;
    logic [YW-1:0]      y_q, y_d;
    logic [G1_IDW-1:0]  last_q, last_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic [YW-1:0]      g1_y;
    logic [G1_IDW-1:0]  win;
    logic               grant_ok;

    // Search starts just past the previous winner and wraps.
    function automatic logic [G1_IDW-1:0] rr_pick(
        input logic [NREQ-1:0]   r,
        input logic [G1_IDW-1:0] last
    );
        logic [G1_IDW-1:0] idx;
        logic              found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = G1_IDW'((int'(last) + k) % NREQ);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    g1_behavioral #(
        .XW (XW),
        .YW (YW)
    ) u_g1 (
        .x (x_q),
        .y (g1_y)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        id_d     = id_q;
        y_d      = y_q;
        last_d   = last_q;
        gnt_d    = '0;
        grant_ok = 1'b0;
        win      = rr_pick(bus.req, last_q);

        case (state_q)
            IDLE: grant_ok = |bus.req;
            EXEC: begin
                y_d     = g1_y;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    grant_ok = |bus.req;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant from IDLE or from a completing RESP looks the same.
        if (grant_ok) begin
            x_d     = bus.req_x[int'(win)*XW +: XW];
            id_d    = win;
            last_d  = win;
            gnt_d   = NREQ'(1) << win;
            state_d = EXEC;
        end

        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            id_q        <= '0;
            y_q         <= '0;
            last_q      <= G1_IDW'(NREQ - 1);
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            id_q        <= id_d;
            y_q         <= y_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_y     = y_q;

endmodule

// File: doc/g1_arbiter.md
G1_ARBITER -- requirements
Module: g1_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters; only the value 4 is required.
REQ-002 SHALL have parameter XW, default 4, meaning operand width into the shared g1 unit.
REQ-003 SHALL have parameter YW, default 2, meaning result width out of the shared g1 unit.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NREQ  per-requester request, level.
REQ-007 req_x  input  NREQ*XW  operands; requester i occupies bits [i*XW +: XW].
REQ-008 gnt  output  NREQ  one-hot grant, one-cycle pulse when an operand is accepted.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  2  index of the requester that owns the result.
REQ-012 rsp_y  output  YW  result from g1 for the granted operand.
REQ-013 rsp_ready  input  1  consumer accepts the result when high together with rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP, and SHALL reset to IDLE.
REQ-015 In IDLE with req != 0, the block SHALL at the next edge latch the winner's operand into x_reg, set id_reg to the winner, pulse gnt[winner] for one cycle, record the winner as last, and enter EXEC.
REQ-016 In IDLE with req == 0, the block SHALL hold all state.
REQ-017 Arbitration SHALL be round-robin, searching from index (last+1) mod 4 upward with wrap; after reset last = 3, so req[0] has top priority.
REQ-018 In EXEC, the block SHALL drive x_reg into g1, capture g1's y into y_reg at the next edge, and enter RESP.
REQ-019 In RESP, rsp_valid SHALL be 1, rsp_id SHALL equal id_reg, and rsp_y SHALL equal y_reg; these SHALL remain stable until the handshake completes.
REQ-020 In RESP with rsp_ready = 0, the block SHALL hold indefinitely and SHALL issue no grant.
REQ-021 In RESP with rsp_ready = 1 and req != 0, the block SHALL arbitrate as in REQ-015 on the same edge and go directly to EXEC.
REQ-022 In RESP with rsp_ready = 1 and req == 0, the block SHALL go to IDLE.
REQ-023 Latency SHALL be: req seen at edge N, gnt high in cycle N+1, rsp_valid high in cycle N+2; the best-case issue interval is 2 cycles.
REQ-024 Requesters SHALL deassert req after seeing gnt; a req still held is treated as a new request and re-arbitrated.
REQ-025 req and req_x SHALL be ignored in EXEC, and in RESP while rsp_ready = 0.
REQ-026 An operand change after its grant SHALL NOT affect the in-flight result.
REQ-027 gnt SHALL never have more than one bit set, and SHALL be 0 outside a grant cycle.

Reset
REQ-028 When rst_n is low, the block SHALL immediately force state = IDLE, gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0, x_reg = 0, and last = 3.
REQ-029 Reset asserted mid-operation (EXEC or RESP) SHALL discard the in-flight result; no rsp_valid SHALL be produced for it after release.
REQ-030 The first edge after rst_n rises SHALL behave as IDLE.

Structure
REQ-031 The state encodings (IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2), XW, YW and NREQ defaults SHALL live in the shared package g1_pkg.
REQ-032 The block SHALL instantiate exactly one g1_behavioral as the shared sub-module, with .x(x_reg) and .y(g1_y).
REQ-033 The round-robin pick SHALL be a combinational function inside g1_arbiter; no other sub-modules are required.

Verification
REQ-034 The bench SHALL check: after reset, req = 4'b0001 with operand 4'b1011 -> gnt = 4'b0001 one cycle later, then rsp_valid = 1, rsp_id = 0, and rsp_y equal to the g1_behavioral y for x = 4'b1011, one cycle after that.
REQ-035 The bench SHALL check: req = 4'b1111 held, rsp_ready = 1, operands 0000/1011/0101/1110 -> grants in order 0, 1, 2, 3, 0, with each rsp_y matching g1 for its operand.
REQ-036 The bench SHALL check: rsp_ready = 0 for 5 cycles in RESP with req = 4'b0100 -> rsp_valid, rsp_id and rsp_y stay stable and gnt stays 0; on release, the next edge grants requester 2.
REQ-037 The bench SHALL check: the requester changes its operand from 4'b0101 to 4'b1110 in the cycle after gnt -> rsp_y equals g1(4'b0101).
REQ-038 The bench SHALL check: rst_n driven low during EXEC -> gnt and rsp_valid drop to 0 asynchronously, and no response appears after release.
REQ-039 The bench SHALL check: req = 4'b1010 after last = 1 -> grant goes to requester 3, and the next grant goes to requester 1.
